// File: rtl/sram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// sram_rw_arbiter
//
// Shares one sram_rw port between two requesters: port 0 (CPU) and port 1
// (DMA). The SRAM is 8-bit async memory behind registered address/control.
// At most one operation is issued per cycle. A read->write bus turnaround
// gap keeps the 74-series tristate drivers from fighting. Each read
// response is routed back to the port that issued the read.
//
// Handshake (both ports): a request transfers in a cycle where
// pN_req_valid_i & pN_req_ready_o. While valid is high and ready is low,
// the requester holds we/addr/wdata stable. A write completes at accept and
// has no response. Read data comes back as a one-cycle pN_rsp_valid_o pulse.
//
// Configuration macro:
//   SRAM_RW_ARB_RR_EN  defined   -> round-robin between the two ports.
//                      undefined -> fixed priority, port 0 always wins.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   pN_req_valid_i/we_i     port N request valid / 1=write 0=read
//   pN_req_addr_i/wdata_i   port N request address / write data
//   pN_req_ready_o          port N request accepted this cycle
//   pN_rsp_valid_o/rdata_o  port N read response pulse / registered read data
//   sram_read_o/write_o     issue strobes to sram_rw (never both high)
//   sram_addr_o/wdata_o     address / write data to sram_rw (0 when idle)
//   sram_read_valid_i       sram_rw read data valid
//   sram_rdata_i            sram_rw read data
//   err_o                   sticky: response and tag pipe disagree
// ---------------------------------------------------------------------------
module sram_rw_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 2,
    parameter int TURNAROUND = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_valid_i,
    input  logic              p0_req_we_i,
    input  logic [ADDR_W-1:0] p0_req_addr_i,
    input  logic [DATA_W-1:0] p0_req_wdata_i,
    output logic              p0_req_ready_o,
    output logic              p0_rsp_valid_o,
    output logic [DATA_W-1:0] p0_rsp_rdata_o,
    input  logic              p1_req_valid_i,
    input  logic              p1_req_we_i,
    input  logic [ADDR_W-1:0] p1_req_addr_i,
    input  logic [DATA_W-1:0] p1_req_wdata_i,
    output logic              p1_req_ready_o,
    output logic              p1_rsp_valid_o,
    output logic [DATA_W-1:0] p1_rsp_rdata_o,
    output logic              sram_read_o,
    output logic              sram_write_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic              sram_read_valid_i,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              err_o
);

    localparam int MASK_W = $clog2(RD_LATENCY + 1);

    logic [2:0]            turn_cnt;
    logic                  elig0, elig1;
    logic                  grant0, grant1, any_grant;
    logic                  pref;
    logic                  sel_we;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic [RD_LATENCY-1:0] tag_vld;
    logic [RD_LATENCY-1:0] tag_port;
    logic                  tail_vld, tail_port;
    logic                  rsp_hit;
    logic [MASK_W-1:0]     mask_cnt;

`ifdef SRAM_RW_ARB_RR_EN
    logic                  rr_ptr;
`endif

    // Grant and SRAM command selection
    always_comb begin
        // A write is only eligible once the turnaround gap after the last read has elapsed.
        elig0 = ~rst_i & p0_req_valid_i & (~p0_req_we_i | (turn_cnt == 3'd0));
        elig1 = ~rst_i & p1_req_valid_i & (~p1_req_we_i | (turn_cnt == 3'd0));
`ifdef SRAM_RW_ARB_RR_EN
        pref = rr_ptr;
`else
        pref = 1'b0;
`endif
        // Eligibility already excludes blocked writes, so a blocked write
        // never takes the slot away from the other port's read.
        grant0    = elig0 & (~elig1 | ~pref);
        grant1    = elig1 & ~grant0;
        any_grant = grant0 | grant1;

        sel_we    = grant1 ? p1_req_we_i    : p0_req_we_i;
        sel_addr  = grant1 ? p1_req_addr_i  : p0_req_addr_i;
        sel_wdata = grant1 ? p1_req_wdata_i : p0_req_wdata_i;

        p0_req_ready_o = grant0;
        p1_req_ready_o = grant1;
        sram_read_o    = any_grant & ~sel_we;
        sram_write_o   = any_grant & sel_we;
        sram_addr_o    = any_grant ? sel_addr  : '0;
        sram_wdata_o   = any_grant ? sel_wdata : '0;
    end

    // Turnaround counter: reloaded on every read issue, otherwise drains to 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            turn_cnt <= 3'd0;
        end else if (sram_read_o) begin
            turn_cnt <= 3'(TURNAROUND);
        end else if (turn_cnt != 3'd0) begin
            turn_cnt <= turn_cnt - 3'd1;
        end
    end

`ifdef SRAM_RW_ARB_RR_EN
    // After any grant the other port becomes preferred.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= 1'b0;
        end else if (any_grant) begin
            rr_ptr <= ~grant1;
        end
    end
`endif

    // Tag pipe tracks {read issued, port} alongside the sram_rw pipeline.
    // The tail lines up with sram_read_valid_i for the same read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_vld  <= '0;
            tag_port <= '0;
        end else begin
            tag_vld[0]  <= sram_read_o;
            tag_port[0] <= grant1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_port[i] <= tag_port[i-1];
            end
        end
    end

    assign tail_vld  = tag_vld[RD_LATENCY-1];
    assign tail_port = tag_port[RD_LATENCY-1];
    assign rsp_hit   = sram_read_valid_i & tail_vld;

    // Response routing; the non-target port keeps its last read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p0_rsp_valid_o <= 1'b0;
            p1_rsp_valid_o <= 1'b0;
            p0_rsp_rdata_o <= '0;
            p1_rsp_rdata_o <= '0;
        end else begin
            p0_rsp_valid_o <= rsp_hit & ~tail_port;
            p1_rsp_valid_o <= rsp_hit & tail_port;
            if (rsp_hit & ~tail_port) p0_rsp_rdata_o <= sram_rdata_i;
            if (rsp_hit & tail_port)  p1_rsp_rdata_o <= sram_rdata_i;
        end
    end

    // sram_rw has no reset, so reads issued before reset can still come out
    // after it. Error checking stays masked until those reads have drained.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_cnt <= MASK_W'(RD_LATENCY);
            err_o    <= 1'b0;
        end else begin
            if (mask_cnt != '0) begin
                mask_cnt <= mask_cnt - 1'b1;
            end else if (sram_read_valid_i != tail_vld) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_rw_arbiter
//
// Directed bench for sram_rw_arbiter. The bench contains a behavioural
// sram_rw model with 2-cycle read latency. Read expectations come from a
// reference memory and go into exp_q as {port, data, due cycle}. A monitor
// pops exp_q whenever a response pulse appears. Round-robin expectations
// follow SRAM_RW_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_sram_rw_arbiter;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 8;
    localparam int RD_LATENCY = 2;
    localparam int TURNAROUND = 1;
    localparam int EW         = 1 + DATA_W + 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              p0_req_valid_i = 1'b0, p0_req_we_i = 1'b0;
    logic [ADDR_W-1:0] p0_req_addr_i = '0;
    logic [DATA_W-1:0] p0_req_wdata_i = '0;
    logic              p1_req_valid_i = 1'b0, p1_req_we_i = 1'b0;
    logic [ADDR_W-1:0] p1_req_addr_i = '0;
    logic [DATA_W-1:0] p1_req_wdata_i = '0;
    logic              p0_req_ready_o, p0_rsp_valid_o, p1_req_ready_o, p1_rsp_valid_o;
    logic [DATA_W-1:0] p0_rsp_rdata_o, p1_rsp_rdata_o;
    logic              sram_read_o, sram_write_o, sram_read_valid_i, err_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_wdata_o, sram_rdata_i;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [EW-1:0]     exp_q[$];
    logic [DATA_W-1:0] ref_mem  [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] sram_mem [0:(1<<ADDR_W)-1];

    logic              mdl_v1 = 1'b0, mdl_v2 = 1'b0, force_rv = 1'b0;
    logic [DATA_W-1:0] mdl_d1 = '0, mdl_d2 = '0;

    sram_rw_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY), .TURNAROUND(TURNAROUND)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_req_valid_i(p0_req_valid_i), .p0_req_we_i(p0_req_we_i),
        .p0_req_addr_i(p0_req_addr_i), .p0_req_wdata_i(p0_req_wdata_i),
        .p0_req_ready_o(p0_req_ready_o), .p0_rsp_valid_o(p0_rsp_valid_o),
        .p0_rsp_rdata_o(p0_rsp_rdata_o),
        .p1_req_valid_i(p1_req_valid_i), .p1_req_we_i(p1_req_we_i),
        .p1_req_addr_i(p1_req_addr_i), .p1_req_wdata_i(p1_req_wdata_i),
        .p1_req_ready_o(p1_req_ready_o), .p1_rsp_valid_o(p1_rsp_valid_o),
        .p1_rsp_rdata_o(p1_rsp_rdata_o),
        .sram_read_o(sram_read_o), .sram_write_o(sram_write_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_read_valid_i(sram_read_valid_i), .sram_rdata_i(sram_rdata_i),
        .err_o(err_o)
    );

    // ---------------- clock / cycle counter / watchdog ----------------
    initial forever #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- sram_rw model (2-cycle read latency, no reset) ----------------
    always @(posedge clk_i) begin
        mdl_v1 <= sram_read_o;
        mdl_d1 <= sram_mem[sram_addr_o];
        mdl_v2 <= mdl_v1;
        mdl_d2 <= mdl_d1;
        if (sram_write_o) sram_mem[sram_addr_o] <= sram_wdata_o;
    end

    assign sram_read_valid_i = mdl_v2 | force_rv;
    assign sram_rdata_i      = mdl_d2;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic check_rsp(input logic port, input logic [DATA_W-1:0] data);
        logic [EW-1:0] e;
        tests++;
        assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL rsp_unexpected: got port %0d data %0h expected no response", port, data);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_port_data_cycle", 64'({port, data, 32'(cyc)}), 64'(e));
        end
    endtask

    always @(negedge clk_i) begin
        if (p0_rsp_valid_o === 1'b1) check_rsp(1'b0, p0_rsp_rdata_o);
        if (p1_rsp_valid_o === 1'b1) check_rsp(1'b1, p1_rsp_rdata_o);
        if (exp_q.size() != 0 && int'(exp_q[0][31:0]) < cyc) begin
            chk("rsp_missing_due_cycle", 64'(cyc), 64'(exp_q[0][31:0]));
            void'(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_p0(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        p0_req_valid_i = v; p0_req_we_i = we; p0_req_addr_i = a; p0_req_wdata_i = d;
    endtask

    task automatic set_p1(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        p1_req_valid_i = v; p1_req_we_i = we; p1_req_addr_i = a; p1_req_wdata_i = d;
    endtask

    // Called at a negedge once inputs are set. Checks the expected grant and
    // SRAM command, books the accepted request, and advances to the next negedge.
    task automatic cycle(input logic g0, input logic g1, input string tag);
        logic              any, ew;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        #1;
        chk({tag, " p0_ready"}, 64'(p0_req_ready_o), 64'(g0));
        chk({tag, " p1_ready"}, 64'(p1_req_ready_o), 64'(g1));
        any = g0 | g1;
        ew  = g1 ? p1_req_we_i    : p0_req_we_i;
        ea  = g1 ? p1_req_addr_i  : p0_req_addr_i;
        ed  = g1 ? p1_req_wdata_i : p0_req_wdata_i;
        chk({tag, " sram_rd_wr_addr"}, 64'({sram_read_o, sram_write_o, sram_addr_o}),
            64'({any & ~ew, any & ew, any ? ea : {ADDR_W{1'b0}}}));
        if (!any || ew) chk({tag, " sram_wdata"}, 64'(sram_wdata_o), 64'(any ? ed : {DATA_W{1'b0}}));
        if (any && ew)  ref_mem[ea] = ed;
        if (any && !ew) exp_q.push_back({g1, ref_mem[ea], 32'(cyc + RD_LATENCY + 1)});
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        set_p0(1'b0, 1'b0, '0, '0);
        set_p1(1'b0, 1'b0, '0, '0);
        repeat (n) cycle(1'b0, 1'b0, "idle");
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        set_p0(1'b0, 1'b0, '0, '0);
        set_p1(1'b0, 1'b0, '0, '0);
        exp_q.delete();
        repeat (n) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ref_mem[i]  = DATA_W'(i) ^ 8'h5A;
            sram_mem[i] = DATA_W'(i) ^ 8'h5A;
        end
        @(negedge clk_i);
        do_reset(2);

        // Reset state
        chk("reset_regs", 64'({p0_rsp_valid_o, p1_rsp_valid_o, p0_rsp_rdata_o, p1_rsp_rdata_o, err_o}), 64'(0));
        idle(3);

        // 1: p0 write then read back, full latency checked via due cycle
        set_p0(1'b1, 1'b1, 14'h1234, 8'hA5);  cycle(1'b1, 1'b0, "t1 wr");
        set_p0(1'b1, 1'b0, 14'h1234, 8'h00);  cycle(1'b1, 1'b0, "t1 rd");
        idle(4);
        chk("t1 err", 64'(err_o), 64'(0));
        chk("t1 drained", 64'(exp_q.size()), 64'(0));

        // 2: both ports reading continuously
        do_reset(1);
        set_p0(1'b1, 1'b0, 14'h0100, '0);
        set_p1(1'b1, 1'b0, 14'h0200, '0);
`ifdef SRAM_RW_ARB_RR_EN
        cycle(1'b1, 1'b0, "t2 c0"); set_p0(1'b1, 1'b0, 14'h0101, '0);
        cycle(1'b0, 1'b1, "t2 c1"); set_p1(1'b1, 1'b0, 14'h0201, '0);
        cycle(1'b1, 1'b0, "t2 c2"); set_p0(1'b1, 1'b0, 14'h0102, '0);
        cycle(1'b0, 1'b1, "t2 c3"); set_p1(1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, "t2 c4"); set_p0(1'b0, 1'b0, '0, '0);
`else
        cycle(1'b1, 1'b0, "t2 c0"); set_p0(1'b1, 1'b0, 14'h0101, '0);
        cycle(1'b1, 1'b0, "t2 c1"); set_p0(1'b1, 1'b0, 14'h0102, '0);
        cycle(1'b1, 1'b0, "t2 c2"); set_p0(1'b1, 1'b0, 14'h0103, '0);
        cycle(1'b1, 1'b0, "t2 c3"); set_p0(1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, "t2 c4"); set_p1(1'b0, 1'b0, '0, '0);
`endif
        idle(4);
        chk("t2 drained", 64'(exp_q.size()), 64'(0));

        // 3: read->write turnaround delays the write by one cycle
        do_reset(1);
        set_p0(1'b1, 1'b0, 14'h0400, '0);
        set_p1(1'b1, 1'b1, 14'h0401, 8'h3C);
        cycle(1'b1, 1'b0, "t3 c0"); set_p0(1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, "t3 c1");
        cycle(1'b0, 1'b1, "t3 c2");
        set_p1(1'b1, 1'b0, 14'h0401, '0);
        cycle(1'b0, 1'b1, "t3 rdback");
        idle(4);
        chk("t3 drained", 64'(exp_q.size()), 64'(0));

        // 4: blocked write does not stall the other port's reads
        do_reset(1);
        set_p0(1'b1, 1'b0, 14'h0500, '0);
        cycle(1'b1, 1'b0, "t4 c0");
        set_p0(1'b1, 1'b0, 14'h0501, '0);
        set_p1(1'b1, 1'b1, 14'h0502, 8'hC3);
        cycle(1'b1, 1'b0, "t4 c1"); set_p0(1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, "t4 c2");
        cycle(1'b0, 1'b1, "t4 c3");
        set_p1(1'b1, 1'b0, 14'h0502, '0);
        cycle(1'b0, 1'b1, "t4 rdback"); set_p1(1'b0, 1'b0, '0, '0);
        idle(4);
        chk("t4 drained", 64'(exp_q.size()), 64'(0));

        // 5: reset with two reads in flight drops them
        do_reset(1);
        idle(3);
        set_p0(1'b1, 1'b0, 14'h0600, '0);
        cycle(1'b1, 1'b0, "t5 c0"); set_p0(1'b0, 1'b0, '0, '0);
        set_p1(1'b1, 1'b0, 14'h0601, '0);
        cycle(1'b0, 1'b1, "t5 c1"); set_p1(1'b0, 1'b0, '0, '0);
        rst_i = 1'b1;
        exp_q.delete();
        set_p0(1'b1, 1'b0, 14'h0602, '0);
        cycle(1'b0, 1'b0, "t5 in_reset");
        rst_i = 1'b0;
        cycle(1'b1, 1'b0, "t5 after_reset");
        idle(5);
        chk("t5 err", 64'(err_o), 64'(0));
        chk("t5 drained", 64'(exp_q.size()), 64'(0));

        // 6: spurious response sets sticky err_o
        chk("t6 err_before", 64'(err_o), 64'(0));
        force_rv = 1'b1;
        @(negedge clk_i);
        force_rv = 1'b0;
        chk("t6 err_set", 64'(err_o), 64'(1));
        idle(3);
        chk("t6 err_sticky", 64'(err_o), 64'(1));
        do_reset(1);
        chk("t6 err_cleared", 64'(err_o), 64'(0));
        idle(3);

        chk("final drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
